// File: rtl/stump_mem_if_pkg.sv
// ---------------------------------------------------------------------------
// stump_mem_if_pkg
// Shared Stump memory-interface definitions: bus FSM state encodings,
// latched access-kind codes and the helper that classifies a new access.
// ---------------------------------------------------------------------------
package stump_mem_if_pkg;

    localparam int unsigned MIF_DW = 16;

    typedef enum logic [1:0] {
        MIF_IDLE = 2'b00,
        MIF_REQ  = 2'b01,
        MIF_DONE = 2'b10
    } mif_state_t;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10
    } mif_kind_t;

    // A store wins over a load when both enables are raised together.
    function automatic mif_kind_t decode_kind(input logic memory,
                                              input logic mem_ren,
                                              input logic mem_wen);
        mif_kind_t kind;
        if (memory && mem_wen) begin
            kind = KIND_STORE;
        end else if (memory && mem_ren) begin
            kind = KIND_LOAD;
        end else begin
            kind = KIND_FETCH;
        end
        return kind;
    endfunction

endpackage

// File: rtl/stump_mem_timer.sv
// ---------------------------------------------------------------------------
// stump_mem_timer
// Watchdog for one bus access. Counts enabled cycles since the last clear and
// flags expire on the last permitted cycle (count == TIMEOUT-1).
// Ports: clk, rst (async, active-low), clr (restart count), en (count this
//        cycle), expire (final cycle of the allowed window).
// ---------------------------------------------------------------------------
module stump_mem_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter; the owning FSM leaves REQ on expire, so the count
    // never exceeds TIMEOUT and cannot wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/stump_mem_if.sv
// ---------------------------------------------------------------------------
// stump_mem_if
// Memory-bus interface for the Stump processor. Converts the control unit's
// FETCH/MEMORY strobes into a request/acknowledge bus access with variable
// wait states, stalls the control FSM until the access finishes, and captures
// fetched instructions into ir and loaded data into mdr. A watchdog abandons
// accesses that are never acknowledged and raises the sticky bus_err.
// Ports:
//   clk, rst (async, active-low)
//   fetch, memory, mem_ren, mem_wen, addr, wdata  - from Stump_control
//   stall, ir, mdr, bus_err                       - to the processor
//   bus_req, bus_we, bus_addr, bus_wdata          - registered bus request
//   bus_rdata, bus_ack                            - bus response
// ---------------------------------------------------------------------------
module stump_mem_if
    import stump_mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              memory,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [MIF_DW-1:0] addr,
    input  logic [MIF_DW-1:0] wdata,
    output logic              stall,
    output logic [MIF_DW-1:0] ir,
    output logic [MIF_DW-1:0] mdr,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [MIF_DW-1:0] bus_addr,
    output logic [MIF_DW-1:0] bus_wdata,
    input  logic [MIF_DW-1:0] bus_rdata,
    input  logic              bus_ack
);

    mif_state_t state_r;
    mif_state_t next_state_s;
    mif_kind_t  kind_r;

    logic start_s;
    logic launch_s;
    logic in_req_s;
    logic ack_s;
    logic timeout_s;
    logic expire_s;
    logic tmr_en_s;

    assign start_s   = fetch | (memory & (mem_ren | mem_wen));
    assign launch_s  = (state_r == MIF_IDLE) & start_s;
    assign in_req_s  = (state_r == MIF_REQ);
    assign ack_s     = in_req_s & bus_ack;
    // Ack on the final watchdog cycle takes priority over the timeout.
    assign timeout_s = in_req_s & ~bus_ack & expire_s;
    assign tmr_en_s  = in_req_s & ~bus_ack;

    // Reset must release the control FSM even while a start strobe is held.
    assign stall = rst & (launch_s | in_req_s);

    stump_mem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch_s),
        .en     (tmr_en_s),
        .expire (expire_s)
    );

    // Bus FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= MIF_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; DONE always returns to IDLE so one idle cycle
    // separates accesses and a lingering start cannot relaunch from DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MIF_IDLE: begin
                if (start_s) begin
                    next_state_s = MIF_REQ;
                end else begin
                    next_state_s = MIF_IDLE;
                end
            end
            MIF_REQ: begin
                if (ack_s || timeout_s) begin
                    next_state_s = MIF_DONE;
                end else begin
                    next_state_s = MIF_REQ;
                end
            end
            MIF_DONE: next_state_s = MIF_IDLE;
            default:  next_state_s = MIF_IDLE;
        endcase
    end

    // Bus request registers, latched access kind and capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 16'h0000;
            bus_wdata <= 16'h0000;
            bus_err   <= 1'b0;
            ir        <= 16'h0000;
            mdr       <= 16'h0000;
            kind_r    <= KIND_FETCH;
        end else if (launch_s) begin
            bus_req   <= 1'b1;
            bus_we    <= memory & mem_wen;
            bus_addr  <= addr;
            bus_wdata <= wdata;
            kind_r    <= decode_kind(memory, mem_ren, mem_wen);
        end else if (ack_s) begin
            bus_req <= 1'b0;
            // The kind latched at launch decides the capture, not the
            // strobes currently presented by the control FSM.
            case (kind_r)
                KIND_FETCH: ir  <= bus_rdata;
                KIND_LOAD:  mdr <= bus_rdata;
                KIND_STORE: ir  <= ir;
                default:    ir  <= ir;
            endcase
        end else if (timeout_s) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stump_mem_if.sv
// ---------------------------------------------------------------------------
// tb_stump_mem_if
// Directed bench for stump_mem_if. The driver pushes the expected outcome of
// each access into a queue; a monitor on the falling edge checks bus fields
// during REQ and pops/compares the outcome when stall drops in DONE.
// ---------------------------------------------------------------------------
module tb_stump_mem_if;

    localparam int TO = 15;

    logic        clk;
    logic        rst;
    logic        fetch, memory, mem_ren, mem_wen;
    logic [15:0] addr, wdata;
    logic        stall;
    logic [15:0] ir, mdr;
    logic        bus_err, bus_req, bus_we;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] mdr;
        logic        err;
        int          nreq;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_ir  = 16'h0000;
    logic [15:0] m_mdr = 16'h0000;
    logic        m_err = 1'b0;

    int   req_cnt    = 0;
    int   stall_cnt  = 0;
    logic stall_prev = 1'b0;

    stump_mem_if #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch),
        .memory    (memory),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .ir        (ir),
        .mdr       (mdr),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: bus fields every REQ cycle, outcome when stall falls.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            req_cnt    = 0;
            stall_cnt  = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall) stall_cnt++;
            if (bus_req) begin
                req_cnt++;
                if (q.size() == 0) begin
                    chk("req_with_expectation", q.size(), 1);
                end else begin
                    chk("bus_addr",  bus_addr,  q[0].addr);
                    chk("bus_we",    bus_we,    q[0].we);
                    chk("bus_wdata", bus_wdata, q[0].wdata);
                end
            end
            if (stall_prev && !stall) begin
                if (q.size() == 0) begin
                    chk("done_with_expectation", q.size(), 1);
                end else begin
                    mon_e = q.pop_front();
                    chk("ir",          ir,        mon_e.ir);
                    chk("mdr",         mdr,       mon_e.mdr);
                    chk("bus_err",     bus_err,   mon_e.err);
                    chk("req_cycles",  req_cnt,   mon_e.nreq);
                    chk("stall_cycles", stall_cnt, mon_e.nreq + 1);
                    chk("req_low_in_done", bus_req, 0);
                end
                req_cnt   = 0;
                stall_cnt = 0;
            end
            stall_prev = stall;
        end
    end

    // One access from IDLE. Called at posedge+1 with the DUT idle.
    // waits = REQ cycles before ack; ack_en=0 lets the watchdog fire.
    task automatic do_access(input bit is_fetch, input bit ren, input bit wen,
                             input logic [15:0] a, input logic [15:0] wd,
                             input int waits, input bit ack_en,
                             input logic [15:0] rd, input bit ack_done);
        exp_t e;
        int   n_noack;
        fetch   = is_fetch;
        memory  = !is_fetch;
        mem_ren = ren;
        mem_wen = wen;
        addr    = a;
        wdata   = wd;
        if (ack_en) begin
            if (is_fetch) m_ir = rd;
            else if (!wen) m_mdr = rd;
        end else begin
            m_err = 1'b1;
        end
        e.ir    = m_ir;
        e.mdr   = m_mdr;
        e.err   = m_err;
        e.nreq  = ack_en ? waits + 1 : TO;
        e.addr  = a;
        e.we    = !is_fetch && wen;
        e.wdata = wd;
        q.push_back(e);
        @(posedge clk); #1;
        n_noack = ack_en ? waits : TO;
        repeat (n_noack) begin
            @(posedge clk); #1;
        end
        if (ack_en) begin
            bus_ack   = 1'b1;
            bus_rdata = rd;
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = 16'h0000;
        end
        // DONE cycle: strobes still held; optional stray ack.
        if (ack_done) begin
            bus_ack   = 1'b1;
            bus_rdata = 16'hDEAD;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("no_launch_from_done", bus_req, 0);
        chk("ir_after_done",  ir,  m_ir);
        chk("mdr_after_done", mdr, m_mdr);
        fetch   = 1'b0;
        memory  = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        fetch = 1'b0; memory = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        addr = 16'h0000; wdata = 16'h0000;
        bus_rdata = 16'h0000; bus_ack = 1'b0;
        #1 rst = 1'b0;
        fetch = 1'b1;
        #2;
        chk("reset_stall_forced", stall, 0);
        chk("reset_bus_req", bus_req, 0);
        chk("reset_ir", ir, 16'h0000);
        chk("reset_mdr", mdr, 16'h0000);
        chk("reset_bus_err", bus_err, 0);
        chk("reset_bus_addr", bus_addr, 16'h0000);
        fetch = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // Zero-wait fetch, 3-wait load, store, combined ren+wen (store).
        do_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 1'b1, 16'hA5C3, 1'b0);
        do_access(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 3, 1'b1, 16'h1234, 1'b0);
        do_access(1'b0, 1'b0, 1'b1, 16'h0300, 16'hBEEF, 1, 1'b1, 16'hFFFF, 1'b0);
        do_access(1'b0, 1'b1, 1'b1, 16'h0301, 16'hCAFE, 0, 1'b1, 16'h0BAD, 1'b0);

        // Stray ack while idle: no capture, no launch.
        bus_ack = 1'b1; bus_rdata = 16'h5555;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 16'h0000;
        chk("idle_ack_ir", ir, m_ir);
        chk("idle_ack_mdr", mdr, m_mdr);
        chk("idle_ack_req", bus_req, 0);
        chk("idle_ack_stall", stall, 0);

        // Fetch with a stray ack in DONE, then a timed-out load, then a fetch.
        do_access(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000, 2, 1'b1, 16'h4321, 1'b1);
        do_access(1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 0, 1'b0, 16'h0000, 1'b0);
        do_access(1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000, 1, 1'b1, 16'h7777, 1'b0);

        // Reset in the middle of a load.
        memory = 1'b1; mem_ren = 1'b1; addr = 16'h0600;
        e.ir = m_ir; e.mdr = m_mdr; e.err = m_err; e.nreq = 0;
        e.addr = 16'h0600; e.we = 1'b0; e.wdata = wdata;
        q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midreset_bus_req", bus_req, 0);
        chk("midreset_stall", stall, 0);
        chk("midreset_ir", ir, 16'h0000);
        chk("midreset_mdr", mdr, 16'h0000);
        chk("midreset_bus_err", bus_err, 0);
        chk("midreset_bus_addr", bus_addr, 16'h0000);
        m_ir = 16'h0000; m_mdr = 16'h0000; m_err = 1'b0;
        memory = 1'b0; mem_ren = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        do_access(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 1'b1, 16'h1111, 1'b0);
        // Ack on the 15th REQ cycle beats the watchdog.
        do_access(1'b0, 1'b1, 1'b0, 16'h0500, 16'h0000, TO - 1, 1'b1, 16'h7E57, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
